rd_sched: RTL and testbench
===========================

RD_SCHED -- requirements
Module: rd_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the read sequencer, range 2..8.
REQ-002 Parameter TMO_CYC, default 15: wait-state timeout in cycles; used only when RD_SCHED_TIMEOUT_EN is defined.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port req  input  N_REQ: per-requester read request, level-sensitive.
REQ-006 Port ws  input  1: memory wait-state; 1 = memory not ready.
REQ-007 Port gnt  output  N_REQ: one-hot grant, held for the whole transaction.
REQ-008 Port rd  output  1: memory read enable, high in states READ and WAIT.
REQ-009 Port rs  output  1: read-sample strobe, one-cycle pulse in state DONE.
REQ-010 Port done  output  N_REQ: one-cycle completion pulse to the granted requester, coincident with rs.
REQ-011 Port err  output  1: one-cycle timeout pulse; tied 0 when timeout is not compiled in.
REQ-012 Port busy  output  1: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL be an FSM with states IDLE, READ, WAIT, DONE; all outputs registered.
REQ-014 IDLE: if any req bit is 1, SHALL select a winner, load gnt, go to READ; otherwise stay.
REQ-015 READ: SHALL go to WAIT unconditionally after exactly one cycle.
REQ-016 WAIT: ws=0 -> DONE; ws=1 -> stay in WAIT.
REQ-017 DONE: SHALL assert rs and done[winner] for one cycle, then return to IDLE; gnt clears on entry to IDLE.
REQ-018 Latency: rd and gnt SHALL rise on the edge after req is sampled high in IDLE; minimum transaction is 4 cycles, IDLE to IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer p; after granting i, p = (i+1) mod N_REQ.
REQ-020 req SHALL be sampled only in IDLE; deasserting req mid-transaction SHALL NOT abort it.
REQ-021 A requester holding req through DONE SHALL be re-eligible in the next IDLE cycle, subject to the pointer.
REQ-022 Exactly one gnt bit SHALL be high outside IDLE; none in IDLE.
REQ-023 A simulation-only ASCII statename signal (e.g. "WAIT") SHALL track the state for bench display.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, pointer 0, timeout counter 0, and gnt/rd/rs/done/err/busy all 0, including mid-transaction.
REQ-025 An aborted transaction SHALL produce no done pulse; after rst falls, arbitration restarts from requester 0.

Configuration
REQ-026 With macro RD_SCHED_TIMEOUT_EN defined: a counter SHALL count WAIT cycles with ws=1; when it reaches TMO_CYC, the FSM SHALL go to IDLE, pulse err for one cycle, produce no rs/done, and advance the pointer.
REQ-027 Without RD_SCHED_TIMEOUT_EN: WAIT SHALL hold indefinitely while ws=1; no counter logic; err constant 0.

Structure
REQ-028 Package rd_sched_pkg SHALL hold the state enum typedef and the N_REQ/TMO_CYC default constants.
REQ-029 The round-robin picker (req, pointer -> one-hot winner, combinational) SHALL be sub-module rd_sched_rr.

Verification
REQ-030 Reset, then req=4'b0001, ws=0 -> gnt=0001 and rd=1 for 2 cycles, then rs=1 and done=0001 for 1 cycle; back in IDLE at cycle 4.
REQ-031 req=4'b1111 held, ws=0 -> grant order 0,1,2,3,0 with one IDLE cycle between transactions.
REQ-032 req=0001, ws=1 for 5 cycles -> WAIT held 5 cycles with rd=1; DONE on the first cycle with ws=0.
REQ-033 TIMEOUT_EN with TMO_CYC=15, ws stuck at 1 -> err pulse after 15 WAIT cycles, no done, next grant to requester 1 if it requests.
REQ-034 rst asserted during WAIT -> all outputs 0 in the same cycle with no clock edge; after release, req=1010 -> gnt=0010.
REQ-035 req deasserted during READ -> transaction still completes with done pulse; gnt stays one-hot throughout (assertion).

Source files
------------

// File: rtl/rd_sched_pkg.sv
// Shared types and default constants for the rd_sched read sequencer.
// Optional wait-state timeout is enabled by defining RD_SCHED_TIMEOUT_EN.
package rd_sched_pkg;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned TMO_CYC_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/rd_sched_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i wins,
// searching upward and wrapping at N_REQ.
module rd_sched_rr
    import rd_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic [PW-1:0]    idx_o,
    output logic             any_o
);

    logic [PW-1:0] k;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = PW'((32'(ptr_i) + i) % N_REQ);
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                win_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/rd_sched.sv
// Round-robin read sequencer: IDLE -> READ -> WAIT -> DONE with registered outputs.
// Define RD_SCHED_TIMEOUT_EN to abort WAIT after TMO_CYC cycles of ws=1 (err pulse).
module rd_sched
    import rd_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ws,
    output logic [N_REQ-1:0] gnt,
    output logic             rd,
    output logic             rs,
    output logic [N_REQ-1:0] done,
    output logic             err,
    output logic             busy
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TMO_CYC < 1) begin : g_bad_param
        $error("rd_sched: N_REQ must be 2..8 and TMO_CYC at least 1");
    end

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             rd_q, rd_d;
    logic             rs_q, rs_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] win_oh;
    logic [PW-1:0]    win_idx;
    logic             win_any;

    rd_sched_rr #(.N_REQ(N_REQ), .PW(PW)) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

`ifdef RD_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
`ifdef RD_SCHED_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_READ;
                    gnt_d   = win_oh;
                    ptr_d   = (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + PW'(1);
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!ws) begin
                    state_d = ST_DONE;
`ifdef RD_SCHED_TIMEOUT_EN
                end else if (cnt_q == CW'(TMO_CYC - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        if (state_d == ST_IDLE) gnt_d = '0;
        rd_d   = (state_d == ST_READ) || (state_d == ST_WAIT);
        rs_d   = (state_d == ST_DONE);
        done_d = rs_d ? gnt_d : '0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rd_q    <= 1'b0;
            rs_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RD_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            busy_q  <= busy_d;
`ifdef RD_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign rd   = rd_q;
    assign rs   = rs_q;
    assign busy = busy_q;
`ifdef RD_SCHED_TIMEOUT_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

    // Simulation aid only: four-character ASCII name of the current state.
    logic [31:0] statename;
    always_comb begin
        statename = "????";
        unique case (state_q)
            ST_IDLE: statename = "IDLE";
            ST_READ: statename = "READ";
            ST_WAIT: statename = "WAIT";
            ST_DONE: statename = "DONE";
            default: statename = "????";
        endcase
    end

endmodule

// File: tb/tb_rd_sched.sv
// Self-checking bench for rd_sched: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_rd_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         ws  = 1'b0;
    logic [N-1:0] gnt, done;
    logic         rd, rs, err, busy;

    int total = 0;
    int bad   = 0;

    rd_sched #(.N_REQ(N), .TMO_CYC(TMO)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .ws   (ws),
        .gnt  (gnt),
        .rd   (rd),
        .rs   (rs),
        .done (done),
        .err  (err),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         ws;
        logic [N-1:0] gnt;
        logic         rd;
        logic         rs;
        logic [N-1:0] done;
        logic         busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] eg, input logic erd,
                           input logic ers, input logic [N-1:0] ed, input logic eerr,
                           input logic ebusy);
        chk({tag, ".gnt"},  32'(gnt),  32'(eg));
        chk({tag, ".rd"},   32'(rd),   32'(erd));
        chk({tag, ".rs"},   32'(rs),   32'(ers));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".err"},  32'(err),  32'(eerr));
        chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    endtask

    function automatic void add(input logic r, input logic [N-1:0] q, input logic w,
                                input logic [N-1:0] g, input logic erd, input logic ers,
                                input logic [N-1:0] d, input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.ws = w; v.gnt = g;
        v.rd = erd; v.rs = ers; v.done = d; v.busy = b;
        tbl.push_back(v);
    endfunction

    // Grant must be one-hot during a transaction and clear while idle.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (busy ? !$onehot(gnt) : (gnt != '0)) begin
                bad++;
                $display("FAIL onehot: gnt=%b busy=%b, expected one-hot when busy else zero", gnt, busy);
            end
        end
    end

    // Reference model: a transaction occupies 1 read cycle, >=1 wait cycles
    // (ends on first ws=0), then 1 completion cycle, then the sequencer is free.
    int   m_phase = 0;   // 0 free, 1 read, 2 waiting, 3 completing
    int   m_owner = 0;
    int   m_ptr   = 0;
    int   m_waits = 0;
    logic m_err   = 1'b0;

    task automatic model_step(input logic r, input logic [N-1:0] q, input logic w);
        m_err = 1'b0;
        if (r) begin
            m_phase = 0; m_ptr = 0; m_waits = 0;
        end else if (m_phase == 0) begin
            if (q != '0) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr + i) % N;
                    if (q[k] && m_phase == 0) begin
                        m_owner = k;
                        m_phase = 1;
                    end
                end
                m_ptr = (m_owner + 1) % N;
            end
        end else if (m_phase == 1) begin
            m_phase = 2; m_waits = 0;
        end else if (m_phase == 2) begin
            if (!w) m_phase = 3;
`ifdef RD_SCHED_TIMEOUT_EN
            else begin
                m_waits++;
                if (m_waits == TMO) begin
                    m_phase = 0;
                    m_err = 1'b1;
                end
            end
`endif
        end else begin
            m_phase = 0;
        end
    endtask

    initial begin
        int n;
        logic saw_done;
        logic [N-1:0] eg;

        // Single read, ws=0: 2 cycles of rd, 1 cycle of rs/done, then idle.
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(0, 4'b0001, 0, 4'b0001, 1, 0, 4'b0000, 1);
        add(0, 4'b0000, 0, 4'b0001, 1, 0, 4'b0000, 1);
        add(0, 4'b0000, 0, 4'b0001, 0, 1, 4'b0001, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
        // All requesting: grants rotate 0,1,2,3,0 with one idle cycle between.
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
        for (int g = 0; g < 5; g++) begin
            add(0, 4'b1111, 0, 4'(1 << (g % N)), 1, 0, 4'b0000, 1);
            add(0, 4'b1111, 0, 4'(1 << (g % N)), 1, 0, 4'b0000, 1);
            add(0, 4'b1111, 0, 4'(1 << (g % N)), 0, 1, 4'(1 << (g % N)), 1);
            add(0, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 0);
        end
        // Wait states: rd held while ws=1, completion on the first ws=0.
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
        add(0, 4'b0001, 1, 4'b0001, 1, 0, 4'b0000, 1);
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 1, 4'b0001, 1, 0, 4'b0000, 1);
        add(0, 4'b0000, 0, 4'b0001, 0, 1, 4'b0001, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);

        #1;
        chk_all("por", '0, 0, 0, '0, 0, 0);
        chk("por.statename", dut.statename, "IDLE");

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; req = tbl[i].req; ws = tbl[i].ws;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].rd, tbl[i].rs,
                    tbl[i].done, 1'b0, tbl[i].busy);
        end

        // Asynchronous reset in the middle of a wait, no clock edge involved.
        @(negedge clk); rst = 1'b0; req = 4'b0100; ws = 1'b1;
        @(negedge clk); req = '0;
        @(negedge clk);
        chk("pre_rst.statename", dut.statename, "WAIT");
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", '0, 0, 0, '0, 0, 0);
        chk("async_rst.statename", dut.statename, "IDLE");
        @(negedge clk); rst = 1'b0; req = 4'b1010; ws = 1'b0;
        @(posedge clk); #1;
        chk_all("post_rst", 4'b0010, 1, 0, '0, 0, 1);
        // Dropping req during READ must not abort the transaction.
        @(negedge clk); req = '0;
        @(posedge clk); #1;
        chk_all("drop_req.wait", 4'b0010, 1, 0, '0, 0, 1);
        @(posedge clk); #1;
        chk_all("drop_req.done", 4'b0010, 0, 1, 4'b0010, 0, 1);
        @(posedge clk); #1;
        chk_all("drop_req.idle", '0, 0, 0, '0, 0, 0);

`ifdef RD_SCHED_TIMEOUT_EN
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; req = 4'b0001; ws = 1'b1;
        @(posedge clk); #1;
        n = 0; saw_done = 1'b0;
        while (!err && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (rs || done != '0) saw_done = 1'b1;
        end
        chk("tmo.edges_to_err", 32'(n), 32'(TMO + 1));
        chk("tmo.no_done", 32'(saw_done), 32'(0));
        chk("tmo.busy", 32'(busy), 32'(0));
        @(negedge clk); req = 4'b0011; ws = 1'b0;
        @(posedge clk); #1;
        chk_all("tmo.next", 4'b0010, 1, 0, '0, 0, 1);
`endif

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = (c == 0) || ($urandom_range(0, 80) == 0);
            req = 4'($urandom);
            ws  = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_step(rst, req, ws);
            #1;
            eg = (m_phase != 0) ? 4'(1 << m_owner) : '0;
            chk_all($sformatf("rand%0d", c), eg, (m_phase == 1 || m_phase == 2),
                    (m_phase == 3), (m_phase == 3) ? eg : '0, m_err, (m_phase != 0));
        end

        @(negedge clk); rst = 1'b0; req = '0; ws = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
